// File: rtl/cacheline_arbiter.sv
// Arbitrates the I-cache and D-cache miss paths onto one physical-memory cacheline port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed D-cache priority.
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MEM_I  = 3'd1,
    MEM_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_line;
  logic              r_op_write;
  logic              w_i_req;
  logic              w_d_req;
  logic              w_d_wins;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_in_mem;

  assign w_i_req  = i_read;
  assign w_d_req  = d_read | d_write;
  assign w_in_mem = (r_state == MEM_I) || (r_state == MEM_D);

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the I-cache held the most recent grant; D wins a tie only then.
  logic r_last_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_i <= 1'b1;
    end else if (w_grant_i) begin
      r_last_i <= 1'b1;
    end else if (w_grant_d) begin
      r_last_i <= 1'b0;
    end
  end

  assign w_d_wins = r_last_i;
`else
  assign w_d_wins = 1'b1;
`endif

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && (!w_i_req || w_d_wins)) begin
          w_grant_d    = 1'b1;
          w_state_next = MEM_D;
        end else if (w_i_req) begin
          w_grant_i    = 1'b1;
          w_state_next = MEM_I;
        end
      end
      MEM_I:   if (pmem_resp) w_state_next = RESP_I;
      MEM_D:   if (pmem_resp) w_state_next = RESP_D;
      RESP_I:  w_state_next = IDLE;
      RESP_D:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_line     <= '0;
      r_op_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_i) begin
        r_addr     <= i_address;
        r_op_write <= 1'b0;
      end else if (w_grant_d) begin
        r_addr     <= d_address;
        r_wdata    <= d_wdata;
        // A simultaneous read+write from the D-cache is serviced as a write.
        r_op_write <= d_write;
      end
      if (w_in_mem && pmem_resp && !r_op_write) begin
        r_line <= pmem_rdata;
      end
    end
  end

  assign pmem_read    = w_in_mem && !r_op_write;
  assign pmem_write   = w_in_mem && r_op_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign i_resp       = (r_state == RESP_I);
  assign d_resp       = (r_state == RESP_D);
  assign i_rdata      = i_resp ? r_line : '0;
  assign d_rdata      = d_resp ? r_line : '0;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed-vector bench for cacheline_arbiter: single requests, ties, read+write, mid-transaction reset.
module tb_cacheline_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MEM_I  = 3'd1;
  localparam logic [2:0] S_MEM_D  = 3'd2;
  localparam logic [2:0] S_RESP_I = 3'd3;
  localparam logic [2:0] S_RESP_D = 3'd4;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [2:0]        o_dbg_state;

  int n_total;
  int n_bad;

  cacheline_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pread"}, LINE_W'(pmem_read), '0);
    chk({tag, "_pwrite"}, LINE_W'(pmem_write), '0);
    chk({tag, "_iresp"}, LINE_W'(i_resp), '0);
    chk({tag, "_dresp"}, LINE_W'(d_resp), '0);
    chk({tag, "_paddr"}, LINE_W'(pmem_address), '0);
    chk({tag, "_pwdata"}, pmem_wdata, '0);
    chk({tag, "_irdata"}, i_rdata, '0);
    chk({tag, "_drdata"}, d_rdata, '0);
    chk({tag, "_state"}, LINE_W'(o_dbg_state), LINE_W'(S_IDLE));
  endtask

  // Called in the IDLE cycle in which the request is sampled (cycle 0).
  // lat = cycle in which memory answers; the granted requester drops on seeing its resp.
  task automatic run_txn(input string tag, input bit exp_d, input bit exp_wr,
                         input logic [ADDR_W-1:0] exp_addr, input logic [LINE_W-1:0] exp_wdata,
                         input int lat, input logic [LINE_W-1:0] line);
    tick();
    chk({tag, "_state_mem"}, LINE_W'(o_dbg_state), LINE_W'(exp_d ? S_MEM_D : S_MEM_I));
    chk({tag, "_paddr"}, LINE_W'(pmem_address), LINE_W'(exp_addr));
    if (exp_wr) chk({tag, "_pwdata"}, pmem_wdata, exp_wdata);
    for (int c = 1; c <= lat; c++) begin
      chk({tag, "_pread"}, LINE_W'(pmem_read), LINE_W'(!exp_wr));
      chk({tag, "_pwrite"}, LINE_W'(pmem_write), LINE_W'(exp_wr));
      chk({tag, "_resp_early"}, LINE_W'({i_resp, d_resp}), '0);
      if (c == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = line;
      end
      tick();
    end
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    chk({tag, "_iresp"}, LINE_W'(i_resp), LINE_W'(!exp_d));
    chk({tag, "_dresp"}, LINE_W'(d_resp), LINE_W'(exp_d));
    chk({tag, "_pstrobe_resp"}, LINE_W'({pmem_read, pmem_write}), '0);
    if (!exp_wr) chk({tag, "_rdata"}, exp_d ? d_rdata : i_rdata, line);
    if (exp_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    tick();
    chk({tag, "_resp_gone"}, LINE_W'({i_resp, d_resp}), '0);
    chk({tag, "_state_idle"}, LINE_W'(o_dbg_state), LINE_W'(S_IDLE));
  endtask

  logic [LINE_W-1:0] line_a5;
  logic [LINE_W-1:0] line_1234;
  logic [LINE_W-1:0] line_b;
  logic [LINE_W-1:0] line_c;
  logic [LINE_W-1:0] wd_2;

  initial begin
    n_total    = 0;
    n_bad      = 0;
    line_a5    = {32{8'hA5}};
    line_1234  = {16{16'h1234}};
    line_b     = {8{32'hBEEF_0001}};
    line_c     = {8{32'hC0DE_7777}};
    wd_2       = {4{64'h0F0F_5555_AAAA_F0F0}};
    rst        = 1'b0;
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // I-cache read, memory answers in cycle 3
    i_read    = 1'b1;
    i_address = 32'h0000_1000;
    run_txn("i_rd", 1'b0, 1'b0, 32'h0000_1000, '0, 3, line_a5);

    // D-cache write-back
    d_write   = 1'b1;
    d_address = 32'h0000_2020;
    d_wdata   = line_1234;
    run_txn("d_wr", 1'b1, 1'b1, 32'h0000_2020, line_1234, 2, '0);

    // Tie: D first, then I after one IDLE cycle, then a third tie goes to D
    i_read    = 1'b1;
    i_address = 32'h0000_3000;
    d_read    = 1'b1;
    d_address = 32'h0000_4000;
    run_txn("tie1_d", 1'b1, 1'b0, 32'h0000_4000, '0, 1, line_b);
    run_txn("tie2_i", 1'b0, 1'b0, 32'h0000_3000, '0, 2, line_c);
    i_read    = 1'b1;
    d_read    = 1'b1;
    d_address = 32'h0000_5040;
    run_txn("tie3_d", 1'b1, 1'b0, 32'h0000_5040, '0, 1, line_a5);

    // Immediate re-tie after a D grant: round-robin favours I, fixed priority favours D
    d_read    = 1'b1;
    d_address = 32'h0000_6060;
`ifdef ARB_ROUND_ROBIN_EN
    run_txn("tie4_i", 1'b0, 1'b0, 32'h0000_3000, '0, 1, line_b);
    run_txn("tie4_d", 1'b1, 1'b0, 32'h0000_6060, '0, 1, line_c);
`else
    run_txn("tie4_d", 1'b1, 1'b0, 32'h0000_6060, '0, 1, line_b);
    run_txn("tie4_i", 1'b0, 1'b0, 32'h0000_3000, '0, 1, line_c);
`endif

    // Read and write together: serviced as a write only
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_7080;
    d_wdata   = wd_2;
    run_txn("d_rw", 1'b1, 1'b1, 32'h0000_7080, wd_2, 2, line_c);

    // Reset in MEM_D: transaction abandoned, no response afterwards
    d_write   = 1'b1;
    d_address = 32'h0000_90A0;
    d_wdata   = line_a5;
    tick();
    chk("rst_pre_state", LINE_W'(o_dbg_state), LINE_W'(S_MEM_D));
    chk("rst_pre_pwrite", LINE_W'(pmem_write), LINE_W'(1'b1));
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    d_write = 1'b0;
    tick();
    chk_all_zero("rst_hold");
    rst        = 1'b1;
    pmem_resp  = 1'b1;
    pmem_rdata = line_b;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_after_dresp", LINE_W'(d_resp), '0);
      chk("rst_after_state", LINE_W'(o_dbg_state), LINE_W'(S_IDLE));
      tick();
    end

    i_read    = 1'b1;
    i_address = 32'h0000_B0C0;
    run_txn("post_rst_i", 1'b0, 1'b0, 32'h0000_B0C0, '0, 2, line_1234);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
